// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the write port of one dc_fifo. A burst is admitted only if it fits entirely.
// Optional sticky error flag err_o enabled by defining FIFO_ARB_ERR_EN.
module fifo_wr_arbiter #(
  parameter int  DWIDTH    = 8,
  parameter int  AWIDTH    = 4,
  parameter int  NREQ      = 4,
  parameter int  MAX_BURST = 4,
  localparam int LWIDTH    = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk_i,
  input  logic                     aclr_n_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*LWIDTH-1:0]   len_i,
  input  logic [NREQ*DWIDTH-1:0]   data_i,
  output logic [NREQ-1:0]          ack_o,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o,
  output logic                     fifo_wr_req_o,
  output logic [DWIDTH-1:0]        fifo_data_o,
  input  logic                     fifo_wr_full_i,
`ifdef FIFO_ARB_ERR_EN
  output logic                     err_o,
`endif
  input  logic [AWIDTH-1:0]        fifo_wr_usedw_i
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [LWIDTH-1:0]   cnt_q, cnt_d;

  logic [AWIDTH:0]     free_s;
  logic [NREQ-1:0]     elig_s;
  logic [NREQ-1:0]     len_bad_s;
  logic [LWIDTH-1:0]   len_k_s;
  logic                win_found_s;
  logic [PW-1:0]       win_idx_s;
  logic [LWIDTH-1:0]   win_len_s;
  int                  rr_idx_s;
  logic                wr_s;

  // When full, usedw may have wrapped to zero, so full overrides it.
  assign free_s = fifo_wr_full_i ? {(AWIDTH+1){1'b0}}
                                 : (AWIDTH+1)'(DEPTH) - {1'b0, fifo_wr_usedw_i};

  // Per-requester eligibility: legal length that fits in the free space
  always_comb begin
    elig_s    = {NREQ{1'b0}};
    len_bad_s = {NREQ{1'b0}};
    len_k_s   = {LWIDTH{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      len_k_s      = len_i[k*LWIDTH +: LWIDTH];
      len_bad_s[k] = (len_k_s == {LWIDTH{1'b0}}) || (len_k_s > LWIDTH'(MAX_BURST));
      elig_s[k]    = req_i[k] && !len_bad_s[k] && ((AWIDTH+1)'(len_k_s) <= free_s);
    end
  end

  // Round-robin search starting at the pointer
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PW{1'b0}};
    rr_idx_s    = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx_s = (int'(ptr_q) + i) % NREQ;
      if (!win_found_s && elig_s[rr_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = PW'(rr_idx_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_len_s = len_i[win_idx_s*LWIDTH +: LWIDTH];

  // Next-state logic for the arbitration FSM
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d            = ST_BURST;
          grant_d            = {NREQ{1'b0}};
          grant_d[win_idx_s] = 1'b1;
          owner_d            = win_idx_s;
          cnt_d              = win_len_s;
          ptr_d              = (win_idx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : win_idx_s + PW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        wr_s = !fifo_wr_full_i;
        if (wr_s) begin
          cnt_d = cnt_q - LWIDTH'(1);
          if (cnt_q == LWIDTH'(1)) begin
            state_d = ST_SETTLE;
            grant_d = {NREQ{1'b0}};
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NREQ{1'b0}};
        cnt_d   = {LWIDTH{1'b0}};
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= {NREQ{1'b0}};
      owner_q <= {PW{1'b0}};
      ptr_q   <= {PW{1'b0}};
      cnt_q   <= {LWIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign busy_o        = (state_q == ST_BURST);
  assign fifo_wr_req_o = wr_s;
  assign ack_o         = wr_s ? grant_q : {NREQ{1'b0}};
  assign fifo_data_o   = (state_q == ST_BURST) ? data_i[owner_q*DWIDTH +: DWIDTH]
                                               : {DWIDTH{1'b0}};

`ifdef FIFO_ARB_ERR_EN
  logic err_q, err_d;

  // Sticky flag: illegal length seen while idle, or full during a burst
  always_comb begin
    err_d = err_q
          | ((state_q == ST_IDLE) && (|(req_i & len_bad_s)))
          | ((state_q == ST_BURST) && fifo_wr_full_i);
  end

  // Error flag register
  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios then random traffic,
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int DWIDTH    = 8;
  localparam int AWIDTH    = 4;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int LWIDTH    = $clog2(MAX_BURST + 1);
  localparam int DEPTH     = 2 ** AWIDTH;

  logic                   clk_i = 1'b0;
  logic                   aclr_n_i;
  logic [NREQ-1:0]        req_i;
  logic [NREQ*LWIDTH-1:0] len_i;
  logic [NREQ*DWIDTH-1:0] data_i;
  logic [NREQ-1:0]        ack_o;
  logic [NREQ-1:0]        grant_o;
  logic                   busy_o;
  logic                   fifo_wr_req_o;
  logic [DWIDTH-1:0]      fifo_data_o;
  logic                   fifo_wr_full_i;
  logic [AWIDTH-1:0]      fifo_wr_usedw_i;
`ifdef FIFO_ARB_ERR_EN
  logic                   err_o;
`endif

  fifo_wr_arbiter #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk_i), .aclr_n_i(aclr_n_i), .req_i(req_i), .len_i(len_i), .data_i(data_i),
    .ack_o(ack_o), .grant_o(grant_o), .busy_o(busy_o), .fifo_wr_req_o(fifo_wr_req_o),
    .fifo_data_o(fifo_data_o), .fifo_wr_full_i(fifo_wr_full_i),
`ifdef FIFO_ARB_ERR_EN
    .err_o(err_o),
`endif
    .fifo_wr_usedw_i(fifo_wr_usedw_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Requester, FIFO-occupancy and reference-model state
  logic [NREQ-1:0] req_b;
  int              len_b [NREQ];
  int              seq   [NREQ];
  int              occ, rd_pct, act_wr, exp_wr;
  bit              force_full;
  int              m_owner, m_rem, m_ptr;
  bit              m_settle, m_err;
  int              gorder [$];
  logic [NREQ-1:0] served, prev_grant;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DWIDTH-1:0] word_of(input int k, input int s);
    return DWIDTH'((k << 5) | (s & 31));
  endfunction

  // One clock cycle: drive inputs, compare outputs, advance model and environment
  task automatic tick();
    int   free, w, pos;
    logic full, eb, ew;
    logic [NREQ-1:0]   eg, ea;
    logic [DWIDTH-1:0] ed;
    for (int k = 0; k < NREQ; k++) begin
      req_i[k]                     = req_b[k];
      len_i[k*LWIDTH +: LWIDTH]    = LWIDTH'(len_b[k]);
      data_i[k*DWIDTH +: DWIDTH]   = word_of(k, seq[k]);
    end
    full            = (occ >= DEPTH) || force_full;
    fifo_wr_full_i  = full;
    fifo_wr_usedw_i = AWIDTH'(occ % DEPTH);
    #1;
    eg = '0; ea = '0; eb = 1'b0; ew = 1'b0; ed = '0; w = -1;
`ifdef FIFO_ARB_ERR_EN
    check_eq("err", err_o, m_err);
`endif
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eb = 1'b1;
      ew = !full;
      ea = ew ? eg : '0;
      ed = word_of(m_owner, seq[m_owner]);
    end else if (!m_settle) begin
      free = full ? 0 : DEPTH - (occ % DEPTH);
      for (int i = 0; i < NREQ; i++) begin
        pos = (m_ptr + i) % NREQ;
        if (w < 0 && req_b[pos] && len_b[pos] >= 1 && len_b[pos] <= MAX_BURST && len_b[pos] <= free)
          w = pos;
      end
    end
    check_eq("grant", grant_o, eg);
    check_eq("ack", ack_o, ea);
    check_eq("busy", busy_o, eb);
    check_eq("wr_req", fifo_wr_req_o, ew);
    check_eq("data", fifo_data_o, ed);

    if (m_owner < 0 && !m_settle) begin
      for (int k = 0; k < NREQ; k++)
        if (req_b[k] && (len_b[k] == 0 || len_b[k] > MAX_BURST)) m_err = 1'b1;
    end
    if (m_owner >= 0 && full) m_err = 1'b1;

    if (grant_o != '0 && prev_grant == '0) begin
      for (int k = 0; k < NREQ; k++)
        if (grant_o[k]) begin gorder.push_back(k); served[k] = 1'b1; end
    end
    prev_grant = grant_o;

    if (fifo_wr_req_o && occ < DEPTH) begin act_wr++; occ++; end
    for (int k = 0; k < NREQ; k++) if (ack_o[k]) seq[k]++;

    if (m_owner >= 0) begin
      if (ew) begin
        exp_wr++;
        m_rem--;
        if (m_rem == 0) begin m_owner = -1; m_settle = 1'b1; end
      end
    end else if (m_settle) begin
      m_settle = 1'b0;
    end else if (w >= 0) begin
      m_owner  = w;
      m_rem    = len_b[w];
      m_ptr    = (w + 1) % NREQ;
      req_b[w] = 1'b0;
    end

    if (occ > 0 && $urandom_range(99) < rd_pct) occ--;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    aclr_n_i = 1'b0;
    #1;
    check_eq("rst_grant", grant_o, '0);
    check_eq("rst_ack", ack_o, '0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_wr_req", fifo_wr_req_o, 1'b0);
    check_eq("rst_data", fifo_data_o, '0);
`ifdef FIFO_ARB_ERR_EN
    check_eq("rst_err", err_o, 1'b0);
`endif
    m_owner = -1; m_settle = 1'b0; m_ptr = 0; m_err = 1'b0;
    req_b = '0; force_full = 1'b0; prev_grant = '0;
    @(negedge clk_i);
    aclr_n_i = 1'b1;
  endtask

  initial begin
    int base, sbase;
    aclr_n_i = 1'b0; req_i = '0; len_i = '0; data_i = '0;
    fifo_wr_full_i = 1'b0; fifo_wr_usedw_i = '0;
    req_b = '0; occ = 0; rd_pct = 0; act_wr = 0; exp_wr = 0; force_full = 1'b0;
    served = '0; prev_grant = '0;
    for (int k = 0; k < NREQ; k++) begin len_b[k] = 0; seq[k] = 0; end
    m_owner = -1; m_rem = 0; m_ptr = 0; m_settle = 1'b0; m_err = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Single 3-word burst from requester 2 into an empty FIFO
    base = act_wr;
    req_b[2] = 1'b1; len_b[2] = 3;
    repeat (7) tick();
    check_eq("t1_words", act_wr - base, 3);
    check_eq("t1_occ", occ, 3);

    // Four len-1 requests from pointer 0, requester 0 re-requests
    do_reset();
    gorder.delete(); base = act_wr;
    for (int k = 0; k < NREQ; k++) begin req_b[k] = 1'b1; len_b[k] = 1; end
    tick(); tick();
    req_b[0] = 1'b1; len_b[0] = 1;
    repeat (13) tick();
    check_eq("t2_words", act_wr - base, 5);
    check_eq("t2_ngrants", gorder.size(), 5);
    for (int i = 0; i < gorder.size() && i < 5; i++)
      check_eq("t2_order", gorder[i], (i < 4) ? i : 0);

    // Long burst that does not fit is skipped, shorter one proceeds
    occ = 14; served = '0; base = act_wr;
    req_b[0] = 1'b1; len_b[0] = 4; req_b[1] = 1'b1; len_b[1] = 2;
    repeat (12) tick();
    check_eq("t3_req0_blocked", served[0], 1'b0);
    check_eq("t3_req1_served", served[1], 1'b1);
    check_eq("t3_words", act_wr - base, 2);
    check_eq("t3_occ", occ, 16);
    rd_pct = 100;
    repeat (16) tick();
    check_eq("t3_req0_late", served[0], 1'b1);

    // Full forced for two cycles at the second word of a 4-word burst
    rd_pct = 0; occ = 0; base = act_wr; sbase = seq[0];
    req_b[0] = 1'b1; len_b[0] = 4;
    tick(); tick();
    force_full = 1'b1;
    tick(); tick();
    force_full = 1'b0;
    repeat (5) tick();
    check_eq("t4_words", act_wr - base, 4);
    check_eq("t4_acks", seq[0] - sbase, 4);
`ifdef FIFO_ARB_ERR_EN
    check_eq("t4_err", err_o, 1'b1);
`endif

    // Reset after two words of a 4-word burst, pointer must restart at 0
    do_reset();
    occ = 0; base = act_wr;
    req_b[1] = 1'b1; len_b[1] = 4;
    repeat (3) tick();
    check_eq("t5_pre_words", act_wr - base, 2);
    do_reset();
    tick(); tick();
    check_eq("t5_post_words", act_wr - base, 2);
    gorder.delete();
    req_b[1] = 1'b1; len_b[1] = 1; req_b[3] = 1'b1; len_b[3] = 1;
    repeat (8) tick();
    check_eq("t5_ngrants", gorder.size(), 2);
    if (gorder.size() >= 2) begin
      check_eq("t5_first", gorder[0], 1);
      check_eq("t5_second", gorder[1], 3);
    end

    // Illegal lengths are never granted
    do_reset();
    served = '0;
    req_b[3] = 1'b1; len_b[3] = 0;
    repeat (6) tick();
    len_b[3] = MAX_BURST + 1;
    repeat (6) tick();
    check_eq("t6_never", served[3], 1'b0);
`ifdef FIFO_ARB_ERR_EN
    check_eq("t6_err", err_o, 1'b1);
`endif
    do_reset();

    // Random traffic with random reads and occasional forced full
    rd_pct = 30;
    repeat (1500) begin
      for (int k = 0; k < NREQ; k++)
        if (!req_b[k] && m_owner != k && $urandom_range(3) == 0) begin
          req_b[k] = 1'b1;
          len_b[k] = $urandom_range(1, MAX_BURST);
        end
      force_full = ($urandom_range(19) == 0);
      tick();
    end
    force_full = 1'b0;
    repeat (8) tick();
    check_eq("rand_words", act_wr, exp_wr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
